m8x8_drain: RTL and testbench
=============================

# m8x8_drain

Output collector that sits directly downstream of the 8x8 systolic multiply array. It consumes the per-row serial result streams (`z_out`, `b_out`, `clear_out`) and reassembles each result tile into one of two tile banks. It then drains completed tiles, one row per beat, through a valid/ready interface to the next stage (write-back or next layer). Double banking lets the array keep running while the previous tile drains.

## Interface
Parameters:
- `WIDTH`, 32: data word width.
- `DROP_FIRST`, 1: when 1, the first `clear_in[r]` per row after reset is swallowed (that stream holds only power-up accumulator contents).

Ports:
- `clk`, input, 1: clock; all state updates on posedge.
- `reset`, input, 1: asynchronous, active-low reset.
- `enable`, input, 1: global array enable; capture side advances only when high.
- `z_in`, input, [WIDTH-1:0] x [7:0] (unpacked): row result streams from the array.
- `b_in`, input, [7:0]: relu-derivative bit per row, sampled alongside `z_in`.
- `clear_in`, input, [7:0]: per-row shift strobe from the array (its `clear_out`).
- `out_valid`, output, 1: a tile row is presented.
- `out_ready`, input, 1: downstream accepts the row.
- `out_data`, output, [WIDTH-1:0] x [7:0]: columns 0..7 of the presented row.
- `out_b`, output, [7:0]: derivative bits of the presented row.
- `out_row`, output, [2:0]: index of the presented row.
- `out_last`, output, 1: high with row 7.
- `busy`, output, 1: any row capturing or any bank full.
- `overflow`, output, 1: sticky protocol/overrun error.
- `tile_count`, output, [15:0]: completed drained tiles; wraps at 65535 -> 0.

## Operation
- Storage: 2 banks x 8 rows x 8 columns of {WIDTH data, 1 b bit}. Per bank: `full` flag plus 8-bit `row_done` mask.
- Per-row capture FSM, independent per row because rows arrive skewed. States are IDLE and CAPT, with a 3-bit column counter `cnt[r]` and a 1-bit bank pointer `wb[r]`. The FSM advances only in cycles with `enable`=1.
- Row FSM transitions:
  - IDLE with `clear_in[r]`=1: if the row is not yet primed and `DROP_FIRST`=1, set primed and stay IDLE. Otherwise, if bank `wb[r]` is not full, go to CAPT with `cnt`=0. If bank `wb[r]` is full, set `overflow`, stay IDLE, and drop the stream.
  - CAPT: write `z_in[r]`/`b_in[r]` to bank `wb[r]`, row r, column `cnt`, then increment `cnt`.
  - At `cnt`=7: set `row_done[r]` in that bank, toggle `wb[r]`, return to IDLE. If `clear_in[r]`=1 in that same cycle (back-to-back tiles), apply the IDLE rules to the new `wb[r]` and go straight to CAPT if permitted.
  - `clear_in[r]`=1 in CAPT with `cnt`<7: set `overflow` and restart at column 0 in the same bank.
- Bank completion: when `row_done`=8'hFF, set `full` and clear `row_done`.
- Drain: read pointer `rb`, row counter `rr`.
  - `out_valid` = `full[rb]`. `out_data`/`out_b` are combinational from bank `rb`, row `rr`. `out_row` = `rr`; `out_last` = (`rr`==7).
  - On a transfer (`out_valid` && `out_ready`), increment `rr`.
  - On a transfer with `rr`==7: clear `full[rb]`, toggle `rb`, increment `tile_count`.
  - The drain ignores `enable`.
- Simultaneous events:
  - A bank freed by the drain in the same cycle a row tries to start into it counts as not full; no overflow.
  - `enable`=0 freezes all capture FSMs and counters; the drain continues.
- Overflow recovery is by reset only.

## Timing
- Reset (asynchronous, active-low) clears:
  - all outputs: `out_valid`=0, `out_row`=0, `out_last`=0, `busy`=0, `overflow`=0, `tile_count`=0, `out_data`=0, `out_b`=0;
  - internal state: `full`, `row_done`, `wb`, `rb`, `rr`, `cnt`, primed bits all 0, and all FSMs in IDLE.
- Reset mid-tile discards all partial and full banks.
- Stream alignment: `clear_in[r]` sampled high at enabled cycle t means column c is sampled at enabled cycle t+1+c, for c = 0..7.
- Latency: `out_valid` rises on the cycle after the edge that writes row 7 (the last row to finish), column 7.
- Sustained throughput: one tile per 8 enabled cycles capture, one row per cycle drain; no overflow while `out_ready` stays high.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.

## Test plan
- Identity: DROP_FIRST pulse, then one tile with `z_in[r]` = 16*r+c at column c and rows skewed by r cycles, `out_ready`=1.
  - Required: 8 beats with `out_data[c]` = 16*`out_row`+c, `out_last` only on row 7, `tile_count`=1, `overflow`=0.
- Back-to-back: 4 tiles at period 8 with `clear_in` re-asserted on the `cnt`=7 cycle.
  - Required: all 4 tiles drain in order, banks alternate, `tile_count`=4, `overflow`=0.
- Backpressure: `out_ready`=0 while 3 tiles are sent.
  - Required: tiles 1-2 fill both banks; tile 3 sets `overflow`=1 and its data never appears.
  - After releasing `out_ready`, tiles 1-2 drain intact.
- Enable stall: drop `enable` for 5 cycles mid-capture, holding `z_in`.
  - Required: captured columns unchanged versus the no-stall run; the drain of an already-full bank proceeds during the stall.
- Early clear: `clear_in[3]` re-pulsed at `cnt`=4.
  - Required: `overflow`=1; row 3 restarts at column 0, and the completed tile holds row 3 from the second stream.
- Async reset: assert `reset`=0 mid-drain of row 5.
  - Required: `out_valid`, `busy`, `tile_count`, `overflow` are 0 immediately, without waiting for a clock edge.
  - The next tile after the DROP_FIRST pulse drains normally.

Source files
------------

// File: rtl/m8x8_drain.sv
`default_nettype none
// ============================================================================
// Module      : m8x8_drain
// Description : Collects the skewed per-row result streams of the 8x8
//               systolic array into two ping-pong tile banks and drains
//               completed tiles one row per beat over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module m8x8_drain #(
    parameter int WIDTH      = 32,
    parameter bit DROP_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] z_in [8],
    input  logic [7:0]       b_in,
    input  logic [7:0]       clear_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data [8],
    output logic [7:0]       out_b,
    output logic [2:0]       out_row,
    output logic             out_last,
    output logic             busy,
    output logic             overflow,
    output logic [15:0]      tile_count
);

    localparam logic [2:0] c_LAST_COL = 3'd7;
    localparam logic [2:0] c_LAST_ROW = 3'd7;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CAPT = 1'b1
    } state_t;

    // Per-row capture state
    state_t           r_state     [8];
    state_t           w_state_nxt [8];
    logic [2:0]       r_cnt       [8];
    logic [2:0]       w_cnt_nxt   [8];
    logic [7:0]       r_wb;
    logic [7:0]       w_wb_nxt;
    logic [7:0]       r_primed;
    logic [7:0]       w_primed_nxt;
    logic [7:0]       w_wr_en;
    logic             w_ovf_set;
    logic [7:0]       w_done_set  [2];

    // Bank bookkeeping
    logic [1:0]       r_full;
    logic [1:0]       w_free;
    logic [1:0]       w_full_eff;
    logic [7:0]       r_row_done  [2];
    logic [7:0]       w_row_done_acc [2];

    // Drain side
    logic             r_rb;
    logic [2:0]       r_rr;
    logic [15:0]      r_tile_cnt;
    logic             r_ovf;
    logic             w_xfer;
    logic             w_any_capt;

    // Tile storage: [bank][row][column]
    logic [WIDTH-1:0] r_mem_z [2][8][8];
    logic             r_mem_b [2][8][8];

    assign out_valid  = r_full[r_rb];
    assign w_xfer     = out_valid & out_ready;
    assign out_row    = r_rr;
    assign out_last   = (r_rr == c_LAST_ROW);
    assign overflow   = r_ovf;
    assign tile_count = r_tile_cnt;
    assign busy       = w_any_capt | (|r_full);

    // A bank whose last row is accepted this cycle is already free for new starts
    always_comb begin
        w_free = 2'b00;
        if (w_xfer && (r_rr == c_LAST_ROW)) begin
            w_free[r_rb] = 1'b1;
        end
        w_full_eff = r_full & ~w_free;
    end

    // Row capture FSMs: next state, column counter, bank pointer, write strobes
    always_comb begin
        logic w_start;
        w_ovf_set     = 1'b0;
        w_wb_nxt      = r_wb;
        w_primed_nxt  = r_primed;
        w_wr_en       = 8'h00;
        w_done_set[0] = 8'h00;
        w_done_set[1] = 8'h00;
        w_start       = 1'b0;
        for (int r = 0; r < 8; r++) begin
            w_state_nxt[r] = r_state[r];
            w_cnt_nxt[r]   = r_cnt[r];
            w_start        = 1'b0;
            if (enable) begin
                case (r_state[r])
                    S_IDLE: begin
                        w_start = clear_in[r];
                    end
                    S_CAPT: begin
                        if (r_cnt[r] == c_LAST_COL) begin
                            // Final column: close this row and flip to the other bank
                            w_wr_en[r]              = 1'b1;
                            w_done_set[r_wb[r]][r]  = 1'b1;
                            w_wb_nxt[r]             = ~r_wb[r];
                            w_state_nxt[r]          = S_IDLE;
                            w_cnt_nxt[r]            = 3'd0;
                            w_start                 = clear_in[r];
                        end else if (clear_in[r]) begin
                            // Stream restarted early: flag it and recapture from column 0
                            w_ovf_set    = 1'b1;
                            w_cnt_nxt[r] = 3'd0;
                        end else begin
                            w_wr_en[r]   = 1'b1;
                            w_cnt_nxt[r] = r_cnt[r] + 3'd1;
                        end
                    end
                    default: begin
                        w_state_nxt[r] = S_IDLE;
                    end
                endcase
                if (w_start) begin
                    if (DROP_FIRST && !r_primed[r]) begin
                        // First stream after reset only carries stale accumulator data
                        w_primed_nxt[r] = 1'b1;
                    end else if (!w_full_eff[w_wb_nxt[r]]) begin
                        w_state_nxt[r] = S_CAPT;
                        w_cnt_nxt[r]   = 3'd0;
                    end else begin
                        w_ovf_set = 1'b1;
                    end
                end
            end
        end
    end

    // Row capture state registers and sticky overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < 8; r++) begin
                r_state[r] <= S_IDLE;
                r_cnt[r]   <= 3'd0;
            end
            r_wb     <= 8'h00;
            r_primed <= 8'h00;
            r_ovf    <= 1'b0;
        end else begin
            for (int r = 0; r < 8; r++) begin
                r_state[r] <= w_state_nxt[r];
                r_cnt[r]   <= w_cnt_nxt[r];
            end
            r_wb     <= w_wb_nxt;
            r_primed <= w_primed_nxt;
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Accumulate finished rows; a bank becomes full the moment its eighth row lands
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_row_done_acc[b] = r_row_done[b] | w_done_set[b];
        end
    end

    // Bank full flags and row-done masks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full        <= 2'b00;
            r_row_done[0] <= 8'h00;
            r_row_done[1] <= 8'h00;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_row_done_acc[b] == 8'hFF) begin
                    r_full[b]     <= 1'b1;
                    r_row_done[b] <= 8'h00;
                end else begin
                    r_full[b]     <= w_full_eff[b];
                    r_row_done[b] <= w_row_done_acc[b];
                end
            end
        end
    end

    // Tile storage writes; contents are qualified by the full flags, so no reset
    always_ff @(posedge clk) begin
        for (int r = 0; r < 8; r++) begin
            if (w_wr_en[r]) begin
                r_mem_z[r_wb[r]][r][r_cnt[r]] <= z_in[r];
                r_mem_b[r_wb[r]][r][r_cnt[r]] <= b_in[r];
            end
        end
    end

    // Drain pointers and completed-tile counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rb       <= 1'b0;
            r_rr       <= 3'd0;
            r_tile_cnt <= 16'd0;
        end else if (w_xfer) begin
            r_rr <= r_rr + 3'd1;
            if (r_rr == c_LAST_ROW) begin
                r_rb       <= ~r_rb;
                r_tile_cnt <= r_tile_cnt + 16'd1;
            end
        end
    end

    // Presented row, forced to zero whenever no row is valid
    always_comb begin
        for (int c = 0; c < 8; c++) begin
            out_data[c] = out_valid ? r_mem_z[r_rb][r_rr][c] : '0;
            out_b[c]    = out_valid & r_mem_b[r_rb][r_rr][c];
        end
    end

    // Any row mid-capture keeps the block busy
    always_comb begin
        w_any_capt = 1'b0;
        for (int r = 0; r < 8; r++) begin
            if (r_state[r] == S_CAPT) begin
                w_any_capt = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_m8x8_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_m8x8_drain
// Description : Self-checking bench for m8x8_drain with a row scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m8x8_drain;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [WIDTH-1:0] z_in [8];
    logic [7:0]       b_in;
    logic [7:0]       clear_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data [8];
    logic [7:0]       out_b;
    logic [2:0]       out_row;
    logic             out_last;
    logic             busy;
    logic             overflow;
    logic [15:0]      tile_count;

    always #5 clk = ~clk;

    m8x8_drain #(
        .WIDTH      (WIDTH),
        .DROP_FIRST (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .z_in       (z_in),
        .b_in       (b_in),
        .clear_in   (clear_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_b      (out_b),
        .out_row    (out_row),
        .out_last   (out_last),
        .busy       (busy),
        .overflow   (overflow),
        .tile_count (tile_count)
    );

    typedef struct packed {
        logic [7:0][WIDTH-1:0] d;
        logic [7:0]            b;
        logic [2:0]            row;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] tz    [4][8][8];
    logic [7:0]       tbits [4][8];
    int               checks      = 0;
    int               errors      = 0;
    int               stall_xfers = 0;
    int               exp_tc      = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference tiles: identity pattern 16*r+c or random words, random b bits
    task automatic gen_tiles(input int n, input bit identity);
        for (int i = 0; i < n; i++) begin
            for (int r = 0; r < 8; r++) begin
                tbits[i][r] = 8'($urandom);
                for (int c = 0; c < 8; c++) begin
                    tz[i][r][c] = identity ? WIDTH'(16 * r + c) : WIDTH'($urandom);
                end
            end
        end
    endtask

    // A tile expected to come out: its 8 rows in order
    task automatic push_tile(input int i);
        exp_t e;
        for (int r = 0; r < 8; r++) begin
            e.row = 3'(r);
            e.b   = tbits[i][r];
            for (int c = 0; c < 8; c++) e.d[c] = tz[i][r][c];
            exp_q.push_back(e);
        end
        exp_tc++;
    endtask

    task automatic prime();
        clear_in = 8'hFF;
        @(posedge clk); #1;
        clear_in = 8'h00;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        clear_in = 8'h00;
        repeat (2) begin @(posedge clk); #1; end
        exp_q.delete();
        exp_tc = 0;
        reset  = 1'b1;
        @(posedge clk); #1;
    endtask

    // Drive n tiles: row r starts at cycle r*skew, one clear every 'period' cycles,
    // column c of a stream one cycle after its clear plus c.
    task automatic send(input int first, input int n, input int period, input int skew,
                        input bit early3, input int stall_at, input bit ready_at_stall);
        int last_cyc, rel, ti, col, sh;
        last_cyc = 7 * skew + period * (n - 1) + 8 + (early3 ? 5 : 0);
        for (int k = 0; k <= last_cyc; k++) begin
            clear_in = 8'h00;
            b_in     = 8'($urandom);
            for (int r = 0; r < 8; r++) begin
                z_in[r] = WIDTH'($urandom);
                sh  = r * skew + ((early3 && r == 3) ? 5 : 0);
                rel = k - sh;
                if (rel >= 0 && (rel % period) == 0 && (rel / period) < n) clear_in[r] = 1'b1;
                if (rel >= 1) begin
                    ti  = (rel - 1) / period;
                    col = (rel - 1) % period;
                    if (ti < n && col < 8) begin
                        z_in[r] = tz[first + ti][r][col];
                        b_in[r] = tbits[first + ti][r][col];
                    end
                end
                if (early3 && r == 3 && k == 0) clear_in[3] = 1'b1;
            end
            if (k == stall_at) begin
                enable = 1'b0;
                if (ready_at_stall) out_ready = 1'b1;
                repeat (5) @(posedge clk);
                #1;
                enable = 1'b1;
            end
            @(posedge clk); #1;
        end
        clear_in = 8'h00;
    endtask

    task automatic wait_drain(input string name);
        int i;
        for (i = 0; i < 300 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk(name, 256'(exp_q.size() == 0), 256'd1);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    // Monitor: pops the scoreboard on each accepted row, checks hold stability
    exp_t                  mon_e;
    logic [7:0][WIDTH-1:0] act_d;
    logic [7:0][WIDTH-1:0] prev_d;
    bit                    prev_held = 1'b0;

    always @(negedge clk) begin
        for (int c = 0; c < 8; c++) act_d[c] = out_data[c];
        if (reset !== 1'b1) begin
            prev_held = 1'b0;
        end else begin
            if (prev_held && out_valid) chk("hold_stable", act_d, prev_d);
            prev_held = out_valid && !out_ready;
            prev_d    = act_d;
            if (out_valid && out_ready) begin
                if (!enable) stall_xfers++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_row: got row %0d data0 %0h, expected no row", out_row, act_d[0]);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("row",  256'(out_row),  256'(mon_e.row));
                    chk("last", 256'(out_last), 256'(mon_e.row == 3'd7));
                    chk("data", act_d,          256'(mon_e.d));
                    chk("b",    256'(out_b),    256'(mon_e.b));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0][WIDTH-1:0] rd;
        bit found;
        reset     = 1'b0;
        enable    = 1'b1;
        out_ready = 1'b1;
        clear_in  = 8'h00;
        b_in      = 8'h00;
        for (int r = 0; r < 8; r++) z_in[r] = '0;

        // Reset state
        @(posedge clk); #1;
        for (int c = 0; c < 8; c++) rd[c] = out_data[c];
        chk("rst_valid",  256'(out_valid),  256'd0);
        chk("rst_busy",   256'(busy),       256'd0);
        chk("rst_ovf",    256'(overflow),   256'd0);
        chk("rst_tcount", 256'(tile_count), 256'd0);
        chk("rst_row",    256'(out_row),    256'd0);
        chk("rst_last",   256'(out_last),   256'd0);
        chk("rst_b",      256'(out_b),      256'd0);
        chk("rst_data",   rd,               256'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Identity tile, rows skewed by r
        prime();
        gen_tiles(1, 1'b1);
        push_tile(0);
        send(0, 1, 9, 1, 1'b0, -1, 1'b0);
        wait_drain("identity_drain");
        chk("identity_tcount", 256'(tile_count), 256'(exp_tc));
        chk("identity_ovf",    256'(overflow),   256'd0);
        chk("identity_busy",   256'(busy),       256'd0);

        // Back-to-back tiles at period 8, aligned rows
        do_reset();
        prime();
        gen_tiles(4, 1'b0);
        for (int i = 0; i < 4; i++) push_tile(i);
        send(0, 4, 8, 0, 1'b0, -1, 1'b0);
        wait_drain("b2b_drain");
        chk("b2b_tcount", 256'(tile_count), 256'(exp_tc));
        chk("b2b_ovf",    256'(overflow),   256'd0);

        // Backpressure: third tile hits two full banks and is lost
        do_reset();
        prime();
        out_ready = 1'b0;
        gen_tiles(3, 1'b0);
        push_tile(0);
        push_tile(1);
        send(0, 3, 9, 1, 1'b0, -1, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        chk("bp_ovf",    256'(overflow),   256'd1);
        chk("bp_valid",  256'(out_valid),  256'd1);
        chk("bp_busy",   256'(busy),       256'd1);
        chk("bp_tcount", 256'(tile_count), 256'd0);
        out_ready = 1'b1;
        wait_drain("bp_drain");
        chk("bp_tcount_end", 256'(tile_count), 256'(exp_tc));

        // Enable stall mid-capture while a full bank drains
        do_reset();
        prime();
        out_ready   = 1'b0;
        stall_xfers = 0;
        gen_tiles(2, 1'b0);
        push_tile(0);
        push_tile(1);
        send(0, 1, 9, 0, 1'b0, -1, 1'b0);
        send(1, 1, 9, 0, 1'b0, 4, 1'b1);
        chk("stall_drain_beats", 256'(stall_xfers), 256'd5);
        wait_drain("stall_drain");
        chk("stall_tcount", 256'(tile_count), 256'(exp_tc));
        chk("stall_ovf",    256'(overflow),   256'd0);

        // Early clear on row 3 at column 4
        do_reset();
        prime();
        out_ready = 1'b1;
        gen_tiles(1, 1'b0);
        push_tile(0);
        send(0, 1, 9, 0, 1'b1, -1, 1'b0);
        wait_drain("early_drain");
        chk("early_ovf",    256'(overflow),   256'd1);
        chk("early_tcount", 256'(tile_count), 256'(exp_tc));

        // Asynchronous reset while row 5 is presented
        gen_tiles(1, 1'b0);
        push_tile(0);
        send(0, 1, 9, 0, 1'b0, -1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (out_valid && out_row == 3'd5) found = 1'b1;
        end
        chk("arst_row5_seen", 256'(found), 256'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid",  256'(out_valid),  256'd0);
        chk("arst_busy",   256'(busy),       256'd0);
        chk("arst_tcount", 256'(tile_count), 256'd0);
        chk("arst_ovf",    256'(overflow),   256'd0);
        exp_q.delete();
        exp_tc = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        prime();
        gen_tiles(1, 1'b0);
        push_tile(0);
        send(0, 1, 9, 1, 1'b0, -1, 1'b0);
        wait_drain("arst_next_drain");
        chk("arst_next_tcount", 256'(tile_count), 256'(exp_tc));
        chk("arst_next_ovf",    256'(overflow),   256'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
